// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: 32-step restoring divider that stalls the
// pipeline, resolves divide-by-zero and signed overflow early, and strobes write-back.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      div_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [3:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [3:0]      rd_out,
    output logic            wb_en
);
    localparam int CW = $clog2(XLEN);
    localparam logic [2:0] OP_DIV  = 3'b001;
    localparam logic [2:0] OP_DIVU = 3'b010;
    localparam logic [2:0] OP_REM  = 3'b011;
    localparam logic [2:0] OP_REMU = 3'b100;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, SETUP, ITERATE, FIXUP, DONE} state_t;

    state_t          r_state, w_next;
    logic [2:0]      r_op;
    logic [3:0]      r_rd;
    logic [XLEN-1:0] r_dvd_mag, r_dvs_mag, r_rem, r_q, r_result;
    logic            r_dvd_neg, r_dvs_neg;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_rd_out;

    logic            w_valid_op, w_accept, w_signed_in, w_is_rem;
    logic            w_div_zero, w_ovf, w_special, w_ge;
    logic [XLEN-1:0] w_dvd_raw, w_special_res, w_diff, w_q_fix, w_r_fix;
    logic [XLEN:0]   w_shift;

    assign w_valid_op  = (div_op >= OP_DIV) && (div_op <= OP_REMU);
    assign w_accept    = (r_state == IDLE) && start && w_valid_op && !flush;
    assign w_signed_in = (div_op == OP_DIV) || (div_op == OP_REM);
    assign w_is_rem    = (r_op == OP_REM) || (r_op == OP_REMU);

    // Sign flags are only ever set for signed ops, so they also encode signedness.
    assign w_div_zero = (r_dvs_mag == '0);
    assign w_ovf      = r_dvd_neg && (r_dvd_mag == MIN_NEG) && r_dvs_neg && (r_dvs_mag == ONE);
    assign w_special  = w_div_zero || w_ovf;
    assign w_dvd_raw  = r_dvd_neg ? -r_dvd_mag : r_dvd_mag;
    assign w_special_res = w_div_zero ? (w_is_rem ? w_dvd_raw : '1)
                                      : (w_is_rem ? '0 : MIN_NEG);

    assign w_shift = {r_rem, r_q[XLEN-1]};
    assign w_ge    = w_shift >= {1'b0, r_dvs_mag};
    assign w_diff  = w_shift[XLEN-1:0] - r_dvs_mag;
    assign w_q_fix = ((r_op == OP_DIV) && (r_dvd_neg ^ r_dvs_neg)) ? -r_q : r_q;
    assign w_r_fix = r_dvd_neg ? -r_rem : r_rem;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_next = SETUP;
                SETUP:   w_next = w_special ? DONE : ITERATE;
                ITERATE: if (r_cnt == '0) w_next = FIXUP;
                FIXUP:   w_next = DONE;
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = (r_state != IDLE);
        stall = w_accept || (r_state == SETUP) || (r_state == ITERATE) || (r_state == FIXUP);
        done  = (r_state == DONE);
        wb_en = done && (r_rd_out != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= '0;
            r_rd      <= '0;
            r_dvd_mag <= '0;
            r_dvs_mag <= '0;
            r_dvd_neg <= 1'b0;
            r_dvs_neg <= 1'b0;
            r_rem     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_rd_out  <= '0;
        end else if (!flush) begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op      <= div_op;
                    r_rd      <= rd_in;
                    r_dvd_neg <= w_signed_in && dividend[XLEN-1];
                    r_dvs_neg <= w_signed_in && divisor[XLEN-1];
                    r_dvd_mag <= (w_signed_in && dividend[XLEN-1]) ? -dividend : dividend;
                    r_dvs_mag <= (w_signed_in && divisor[XLEN-1]) ? -divisor : divisor;
                end
                SETUP: begin
                    if (w_special) begin
                        r_result <= w_special_res;
                        r_rd_out <= r_rd;
                    end else begin
                        r_rem <= '0;
                        r_q   <= r_dvd_mag;
                        r_cnt <= CW'(XLEN - 1);
                    end
                end
                ITERATE: begin
                    r_rem <= w_ge ? w_diff : w_shift[XLEN-1:0];
                    r_q   <= {r_q[XLEN-2:0], w_ge};
                    r_cnt <= r_cnt - 1'b1;
                end
                FIXUP: begin
                    r_result <= w_is_rem ? w_r_fix : w_q_fix;
                    r_rd_out <= r_rd;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign rd_out = r_rd_out;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer: latency, results, special cases,
// start/flush interaction and asynchronous reset.
module tb_div_sequencer;
    localparam logic [2:0] OP_DIV  = 3'b001;
    localparam logic [2:0] OP_DIVU = 3'b010;
    localparam logic [2:0] OP_REM  = 3'b011;
    localparam logic [2:0] OP_REMU = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  div_op;
    logic [31:0] dividend, divisor;
    logic [3:0]  rd_in;
    logic        flush;
    logic        busy, stall, done, wb_en;
    logic [31:0] result;
    logic [3:0]  rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    div_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .div_op(div_op),
        .dividend(dividend), .divisor(divisor), .rd_in(rd_in), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .result(result),
        .rd_out(rd_out), .wb_en(wb_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op and holds start until done; poke re-pulses start with new operands mid-ITERATE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] rd,
                          input logic [31:0] exp_res, input int exp_lat, input bit poke);
        int cyc    = 0;
        int stalls = 0;
        bit got    = 0;
        @(posedge clk); #1;
        start = 1'b1; div_op = op; dividend = a; divisor = b; rd_in = rd;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (stall) stalls++;
                if (poke && cyc == 12) begin
                    start = 1'b0; div_op = OP_DIVU; dividend = 32'd12345; divisor = 32'd5; rd_in = 4'd15;
                end
                if (poke && cyc == 13) start = 1'b1;
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_rd_out"}, 32'(rd_out), 32'(rd));
        check({tag, "_wb_en"}, 32'(wb_en), 32'(rd != 4'd0));
        @(posedge clk); #1;
        start = 1'b0; div_op = 3'b000;
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int done_cnt;
        rst = 1'b1; start = 1'b0; div_op = 3'b000; dividend = '0; divisor = '0;
        rd_in = '0; flush = 1'b0;
        #12;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_stall",  32'(stall),  32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_wb_en",  32'(wb_en),  32'd0);
        check("rst_result", result,      32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
        @(negedge clk); rst = 1'b0;

        run_op("div_20_m3",    OP_DIV,  32'd20,        32'hFFFF_FFFD, 4'd5, 32'hFFFF_FFFA, 35, 1'b0);
        run_op("rem_m20_3",    OP_REM,  32'hFFFF_FFEC, 32'd3,         4'd1, 32'hFFFF_FFFE, 35, 1'b0);
        run_op("remu_big_3",   OP_REMU, 32'hFFFF_FFEC, 32'd3,         4'd2, 32'd2,         35, 1'b0);
        run_op("divu_max_2",   OP_DIVU, 32'hFFFF_FFFF, 32'd2,         4'd3, 32'h7FFF_FFFF, 35, 1'b1);
        run_op("divu_by0",     OP_DIVU, 32'd7,         32'd0,         4'd4, 32'hFFFF_FFFF, 2,  1'b0);
        run_op("rem_by0",      OP_REM,  32'd7,         32'd0,         4'd6, 32'd7,         2,  1'b0);
        run_op("rem_neg_by0",  OP_REM,  32'hFFFF_FFEC, 32'd0,         4'd7, 32'hFFFF_FFEC, 2,  1'b0);
        run_op("div_ovf",      OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 32'h8000_0000, 2,  1'b0);
        run_op("rem_ovf",      OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 4'd9, 32'd0,         2,  1'b0);
        run_op("div_rd0",      OP_DIV,  32'd100,       32'd7,         4'd0, 32'd14,        35, 1'b0);
        run_op("div_9_2",      OP_DIV,  32'd9,         32'd2,         4'd12, 32'd4,        35, 1'b0);

        // Flush ten iterations in: back to IDLE, no done, previous result retained.
        @(posedge clk); #1;
        start = 1'b1; div_op = OP_DIV; dividend = 32'd1000; divisor = 32'd3; rd_in = 4'd10;
        repeat (12) @(negedge clk);
        check("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_result_kept", result, 32'd4);
        check("flush_rd_kept", 32'(rd_out), 32'd12);
        flush = 1'b0; start = 1'b0; div_op = 3'b000;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("flush_no_done", 32'(done_cnt), 32'd0);

        // Flush and start together in IDLE: not accepted.
        @(posedge clk); #1;
        start = 1'b1; div_op = OP_DIV; dividend = 32'd50; divisor = 32'd5; rd_in = 4'd3; flush = 1'b1;
        @(negedge clk);
        check("flush_start_stall", 32'(stall), 32'd0);
        @(negedge clk);
        check("flush_start_busy", 32'(busy), 32'd0);
        start = 1'b0; div_op = 3'b000; flush = 1'b0;

        // Asynchronous reset mid-ITERATE, checked before any clock edge.
        @(posedge clk); #1;
        start = 1'b1; div_op = OP_DIV; dividend = 32'd1000; divisor = 32'd3; rd_in = 4'd11;
        repeat (15) @(negedge clk);
        check("arst_busy_before", 32'(busy), 32'd1);
        #1;
        start = 1'b0; div_op = 3'b000; rst = 1'b1;
        #1;
        check("arst_busy",   32'(busy),   32'd0);
        check("arst_stall",  32'(stall),  32'd0);
        check("arst_done",   32'(done),   32'd0);
        check("arst_result", result,      32'd0);
        check("arst_rd_out", 32'(rd_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("arst_wait_idle", 32'(busy), 32'd0);

        run_op("div_100_7", OP_DIV, 32'd100, 32'd7, 4'd3, 32'd14, 35, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
